wb_writer: RTL and testbench

Writeback-side driver of the register file's single write port. Merges single-cycle ALU results with buffered long-latency (load/divide) results into one registered write per cycle (`wb_en`, `wb_addr`, `write_data`). Optionally keeps a pending-destination scoreboard so decode can stall on registers whose long-latency result has not yet reached the register file. Sits between the execute/memory stages and the register file.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_fifo.sv | 64 ++++++
 rtl/wb_writer.sv | 123 ++++++++++++
 tb/tb_wb_writer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file writeback path.
package wb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 6;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_LSU
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests buffering long-latency results.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  wb_req_t                  data_i,
    input  logic                     pop_i,
    output wb_req_t                  data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] CntFull = (PtrW + 1)'(Depth);
    localparam logic [PtrW:0] CntOne = (PtrW + 1)'(1);
    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

    wb_req_t           mem_q [Depth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CntFull);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
        if (do_push && !do_pop) count_d = count_q + CntOne;
        if (do_pop && !do_push) count_d = count_q - CntOne;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/wb_writer.sv
// Register-file write-port driver merging ALU and buffered long-latency results.
// Optional pending-destination scoreboard enabled by defining WB_SCOREBOARD_EN.
module wb_writer
    import wb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [ADDR_W-1:0]             alu_addr,
    input  logic [DATA_W-1:0]             alu_data,
    output logic                          alu_stall,
    input  logic                          lsu_valid,
    output logic                          lsu_ready,
    input  logic [ADDR_W-1:0]             lsu_addr,
    input  logic [DATA_W-1:0]             lsu_data,
    input  logic                          pend_mark,
    input  logic [ADDR_W-1:0]             pend_addr,
    input  logic [ADDR_W-1:0]             rs1_addr,
    input  logic [ADDR_W-1:0]             rs2_addr,
    output logic                          rs1_busy,
    output logic                          rs2_busy,
    output logic                          wb_en,
    output logic [ADDR_W-1:0]             wb_addr,
    output logic [DATA_W-1:0]             write_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    wb_req_t  fifo_head;
    logic     fifo_full, fifo_empty, fifo_push, fifo_pop;
    wb_src_e  src;
    wb_req_t  wb_req_q, wb_req_d;
    logic     wb_en_q, wb_en_d;
    logic     wb_lsu_q, wb_lsu_d;

    assign lsu_ready = !fifo_full;
    assign alu_stall = fifo_full;
    assign fifo_push = lsu_valid && lsu_ready;

    wb_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (fifo_push),
        .data_i  ('{addr: lsu_addr, data: lsu_data}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // A full buffer outranks the ALU so long-latency results cannot deadlock.
    always_comb begin
        src      = SRC_NONE;
        fifo_pop = 1'b0;
        if (fifo_full) begin
            src      = SRC_LSU;
            fifo_pop = 1'b1;
        end else if (alu_valid) begin
            src = SRC_ALU;
        end else if (!fifo_empty) begin
            src      = SRC_LSU;
            fifo_pop = 1'b1;
        end
    end

    always_comb begin
        wb_req_d = wb_req_q;
        unique case (src)
            SRC_ALU: wb_req_d = '{addr: alu_addr, data: alu_data};
            SRC_LSU: wb_req_d = fifo_head;
            default: ;
        endcase
        wb_en_d  = (src != SRC_NONE) && (wb_req_d.addr != '0);
        wb_lsu_d = wb_en_d && (src == SRC_LSU);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_req_q <= '0;
            wb_en_q  <= 1'b0;
            wb_lsu_q <= 1'b0;
        end else begin
            wb_req_q <= wb_req_d;
            wb_en_q  <= wb_en_d;
            wb_lsu_q <= wb_lsu_d;
        end
    end

    assign wb_en      = wb_en_q;
    assign wb_addr    = wb_req_q.addr;
    assign write_data = wb_req_q.data;

`ifdef WB_SCOREBOARD_EN
    localparam int unsigned NumRegs = 2 ** ADDR_W;

    logic [NumRegs-1:0] busy_q, busy_d;

    // Clear lags the write by one cycle; a same-cycle mark must survive it.
    always_comb begin
        busy_d = busy_q;
        if (wb_lsu_q) busy_d[wb_addr] = 1'b0;
        if (pend_mark && (pend_addr != '0)) busy_d[pend_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    assign rs1_busy = (rs1_addr != '0) && busy_q[rs1_addr];
    assign rs2_busy = (rs2_addr != '0) && busy_q[rs2_addr];
`else
    logic unused_sb;
    assign unused_sb = ^{pend_mark, pend_addr, rs1_addr, rs2_addr, wb_lsu_q};
    assign rs1_busy  = 1'b0;
    assign rs2_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_wb_writer.sv
// Directed self-checking bench for wb_writer (arbitration, address 0, full FIFO, scoreboard).
module tb_wb_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_stall, lsu_valid, lsu_ready, pend_mark;
    logic [5:0]  alu_addr, lsu_addr, pend_addr, rs1_addr, rs2_addr, wb_addr;
    logic [31:0] alu_data, lsu_data, write_data;
    logic        rs1_busy, rs2_busy, wb_en;
    logic [2:0]  fifo_count;

    int total  = 0;
    int passed = 0;

    wb_writer #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .alu_stall  (alu_stall),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_addr   (lsu_addr),
        .lsu_data   (lsu_data),
        .pend_mark  (pend_mark),
        .pend_addr  (pend_addr),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .write_data (write_data),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wb(input string tag, input logic en, input logic [5:0] a,
                            input logic [31:0] d);
        check({tag, "_en"}, 64'(wb_en), 64'(en));
        check({tag, "_addr"}, 64'(wb_addr), 64'(a));
        check({tag, "_data"}, 64'(write_data), 64'(d));
    endtask

    initial begin
        rst = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;
        pend_mark = 1'b0; pend_addr = '0; rs1_addr = '0; rs2_addr = '0;
        repeat (2) tick();
        check_wb("rst_in", 1'b0, 6'd0, 32'd0);
        check("rst_in_cnt", 64'(fifo_count), 64'd0);
        check("rst_in_ready", 64'(lsu_ready), 64'd1);
        check("rst_in_stall", 64'(alu_stall), 64'd0);
        rst = 1'b1;
        tick();
        check_wb("rst_out", 1'b0, 6'd0, 32'd0);
        check("rst_out_ready", 64'(lsu_ready), 64'd1);

        // ALU result lands one cycle later.
        alu_valid = 1'b1; alu_addr = 6'd5; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        check_wb("alu5", 1'b1, 6'd5, 32'hDEADBEEF);
        tick();
        check("alu5_done", 64'(wb_en), 64'd0);

        // Address 0 from both sources is consumed silently.
        alu_valid = 1'b1; alu_addr = 6'd0; alu_data = 32'h1234;
        lsu_valid = 1'b1; lsu_addr = 6'd0; lsu_data = 32'h55;
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        check("a0_alu_en", 64'(wb_en), 64'd0);
        check("a0_cnt1", 64'(fifo_count), 64'd1);
        tick();
        check("a0_lsu_en", 64'(wb_en), 64'd0);
        check("a0_cnt0", 64'(fifo_count), 64'd0);

        // Fill the FIFO while the ALU competes every cycle.
        alu_valid = 1'b1; alu_addr = 6'd3; alu_data = 32'hA1;
        for (int i = 0; i < 4; i++) begin
            lsu_valid = 1'b1; lsu_addr = 6'(10 + i); lsu_data = 32'h100 + 32'(i);
            if (i > 0) check_wb($sformatf("fill_alu%0d", i), 1'b1, 6'd3, 32'hA1);
            check($sformatf("fill_rdy%0d", i), 64'(lsu_ready), 64'd1);
            tick();
        end
        lsu_valid = 1'b0;
        check("full_cnt", 64'(fifo_count), 64'd4);
        check("full_ready", 64'(lsu_ready), 64'd0);
        check("full_stall", 64'(alu_stall), 64'd1);
        tick();
        check_wb("head0", 1'b1, 6'd10, 32'h100);
        check("head0_cnt", 64'(fifo_count), 64'd3);
        check("head0_stall", 64'(alu_stall), 64'd0);
        tick();
        alu_valid = 1'b0;
        check_wb("held_alu", 1'b1, 6'd3, 32'hA1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check_wb($sformatf("drain%0d", i), 1'b1, 6'(10 + i), 32'h100 + 32'(i));
            check($sformatf("drain_cnt%0d", i), 64'(fifo_count), 64'(3 - i));
        end
        tick();
        check("drain_idle", 64'(wb_en), 64'd0);

`ifdef WB_SCOREBOARD_EN
        pend_mark = 1'b1; pend_addr = 6'd7; rs1_addr = 6'd7; rs2_addr = 6'd0;
        tick();
        pend_mark = 1'b0;
        check("sb7_set", 64'(rs1_busy), 64'd1);
        check("sb_r0", 64'(rs2_busy), 64'd0);
        lsu_valid = 1'b1; lsu_addr = 6'd7; lsu_data = 32'h77;
        tick();
        lsu_valid = 1'b0;
        check("sb7_q", 64'(rs1_busy), 64'd1);
        tick();
        check_wb("sb7_wb", 1'b1, 6'd7, 32'h77);
        check("sb7_at_m", 64'(rs1_busy), 64'd1);
        tick();
        check("sb7_clr", 64'(rs1_busy), 64'd0);

        pend_mark = 1'b1; pend_addr = 6'd9; rs2_addr = 6'd9;
        tick();
        pend_mark = 1'b0;
        lsu_valid = 1'b1; lsu_addr = 6'd9; lsu_data = 32'h99;
        tick();
        lsu_valid = 1'b0;
        tick();
        check_wb("sb9_wb", 1'b1, 6'd9, 32'h99);
        pend_mark = 1'b1; pend_addr = 6'd9;
        tick();
        pend_mark = 1'b0;
        check("sb9_setwins", 64'(rs2_busy), 64'd1);
        tick();
        check("sb9_hold", 64'(rs2_busy), 64'd1);
`else
        pend_mark = 1'b1; pend_addr = 6'd7; rs1_addr = 6'd7; rs2_addr = 6'd9;
        tick();
        pend_mark = 1'b0;
        check("nosb_rs1", 64'(rs1_busy), 64'd0);
        check("nosb_rs2", 64'(rs2_busy), 64'd0);
`endif

        // Reset mid-operation discards buffered entries.
        alu_valid = 1'b1; alu_addr = 6'd4; alu_data = 32'h44;
        lsu_valid = 1'b1; lsu_addr = 6'd20; lsu_data = 32'h20;
        tick();
        lsu_valid = 1'b0;
        check("mid_cnt", 64'(fifo_count), 64'd1);
        rst = 1'b0;
        #1;
        alu_valid = 1'b0;
        check("mid_rst_cnt", 64'(fifo_count), 64'd0);
        check("mid_rst_en", 64'(wb_en), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("post_rst_en", 64'(wb_en), 64'd0);
        check("post_rst_cnt", 64'(fifo_count), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
